// File: rtl/layered_color_mapper_pkg.sv
// Shared types, screen codes and background colour rule for the layered colour mapper.
package layered_cm_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam logic [2:0] SCR_TITLE = 3'b000;
   localparam logic [2:0] SCR_PLAY  = 3'b001;
   localparam logic [2:0] SCR_PLAY2 = 3'b010;
   localparam logic [2:0] SCR_END   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FADE_OUT,
      ST_FADE_IN
   } fade_state_t;

   // Gradients use only the coarse coordinate bits, so callers pass x[9:3] and y[9:3].
   function automatic rgb_t bg_color(input logic [2:0] screen,
                                     input logic [6:0] x_coarse,
                                     input logic [6:0] y_coarse);
      rgb_t c;
      c = '0;
      case (screen)
         SCR_TITLE: c.r = 8'h7F - {1'b0, x_coarse};
         SCR_PLAY:  c.r = 8'h70;
         SCR_PLAY2: c.r = 8'h11 - {1'b0, y_coarse};
         SCR_END:   c.g = 8'h7F - {1'b0, x_coarse};
         default:   c.b = 8'h77;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/layered_color_mapper_if.sv
// Pixel, object and colour signals between game logic, the mapper and the DAC.
interface layered_color_mapper_if #(
   parameter int N_OBJ   = 4,
   parameter int COORD_W = 10
);
   logic                       frame_start;
   logic                       pix_valid_in;
   logic [COORD_W-1:0]         DrawX;
   logic [COORD_W-1:0]         DrawY;
   logic [2:0]                 currScreen;
   logic [N_OBJ-1:0]           obj_en;
   logic [N_OBJ*COORD_W-1:0]   obj_x;
   logic [N_OBJ*COORD_W-1:0]   obj_y;
   logic [N_OBJ*8-1:0]         obj_r;
   logic [N_OBJ*24-1:0]        obj_rgb;
   logic                       pix_valid_out;
   logic [7:0]                 Red;
   logic [7:0]                 Green;
   logic [7:0]                 Blue;
   logic                       fade_busy;

   modport master (
      output frame_start, pix_valid_in, DrawX, DrawY, currScreen,
             obj_en, obj_x, obj_y, obj_r, obj_rgb,
      input  pix_valid_out, Red, Green, Blue, fade_busy
   );

   modport slave (
      input  frame_start, pix_valid_in, DrawX, DrawY, currScreen,
             obj_en, obj_x, obj_y, obj_r, obj_rgb,
      output pix_valid_out, Red, Green, Blue, fade_busy
   );
endinterface

// File: rtl/layered_color_mapper_circle_hit.sv
// Combinational point-in-circle test; widths are chosen so the squared distance cannot overflow.
module circle_hit #(
   parameter int COORD_W = 10
) (
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [COORD_W-1:0] px,
   input  logic [COORD_W-1:0] py,
   input  logic [7:0]         radius,
   input  logic               en,
   output logic               hit
);
   localparam int DW = COORD_W + 2;
   localparam int SW = 2 * DW + 1;

   logic signed [DW-1:0] dx, dy;
   logic signed [SW-1:0] dx_w, dy_w, dist_s;
   logic        [SW-1:0] dist2, rad2;

   assign dx     = signed'({2'b00, px}) - signed'({2'b00, cx});
   assign dy     = signed'({2'b00, py}) - signed'({2'b00, cy});
   assign dx_w   = SW'(dx);
   assign dy_w   = SW'(dy);
   assign dist_s = dx_w * dx_w + dy_w * dy_w;
   assign dist2  = $unsigned(dist_s);
   assign rad2   = SW'(radius) * SW'(radius);
   assign hit    = en & (dist2 <= rad2);
endmodule

// File: rtl/layered_color_mapper.sv
// Two-stage colour pipeline: prioritised circle objects over a screen background,
// scaled by a frame-synchronous cross-fade level.
module layered_color_mapper
   import layered_cm_pkg::*;
#(
   parameter int         N_OBJ      = 4,
   parameter int         COORD_W    = 10,
   parameter int         FADE_SHIFT = 3,
   parameter logic [7:0] SHOW_MASK  = 8'b0000_0110
) (
   input logic                  CLK,
   input logic                  Reset,
   layered_color_mapper_if.slave bus
);
   localparam int              LW   = FADE_SHIFT + 1;
   localparam int              PW   = 8 + FADE_SHIFT + 1;
   localparam logic [LW-1:0]   LMAX = LW'(2 ** FADE_SHIFT);

   fade_state_t      state;
   logic [LW-1:0]    level;
   logic [2:0]       shown_screen;
   logic             fade_busy_q;

   logic [N_OBJ-1:0] hit_c;
   logic [N_OBJ-1:0] s1_hit;
   rgb_t             s1_bg;
   logic             s1_show;
   logic [LW-1:0]    s1_level;
   logic             s1_valid;
   rgb_t             sel_c;
   rgb_t             out_q;
   logic             out_valid_q;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [LW-1:0] lvl);
      logic [PW-1:0] p;
      p = PW'(c) * PW'(lvl);
      return p[FADE_SHIFT +: 8];
   endfunction

   for (genvar i = 0; i < N_OBJ; i++) begin : g_obj
      circle_hit #(.COORD_W(COORD_W)) u_hit (
         .cx     (bus.obj_x[i*COORD_W +: COORD_W]),
         .cy     (bus.obj_y[i*COORD_W +: COORD_W]),
         .px     (bus.DrawX),
         .py     (bus.DrawY),
         .radius (bus.obj_r[i*8 +: 8]),
         .en     (bus.obj_en[i]),
         .hit    (hit_c[i])
      );
   end

   // Fade state, level and shown screen only move on frame_start, so a frame never tears.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state        <= ST_IDLE;
         level        <= LMAX;
         shown_screen <= SCR_TITLE;
         fade_busy_q  <= 1'b0;
      end else if (bus.frame_start) begin
         case (state)
            ST_IDLE: begin
               if (bus.currScreen != shown_screen) begin
                  state       <= ST_FADE_OUT;
                  fade_busy_q <= 1'b1;
               end
            end
            ST_FADE_OUT: begin
               if (bus.currScreen == shown_screen) begin
                  state <= ST_FADE_IN;
               end else if (level == '0) begin
                  shown_screen <= bus.currScreen;
                  state        <= ST_FADE_IN;
               end else begin
                  level <= level - 1'b1;
               end
            end
            ST_FADE_IN: begin
               if (bus.currScreen != shown_screen) begin
                  state <= ST_FADE_OUT;
               end else if (level >= LMAX - 1'b1) begin
                  level       <= LMAX;
                  state       <= ST_IDLE;
                  fade_busy_q <= 1'b0;
               end else begin
                  level <= level + 1'b1;
               end
            end
            default: begin
               state       <= ST_IDLE;
               fade_busy_q <= 1'b0;
            end
         endcase
      end
   end

   // Screen visibility and level travel with the pixel so stage 2 sees a consistent frame.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         s1_valid <= 1'b0;
         s1_hit   <= '0;
         s1_bg    <= '0;
         s1_show  <= 1'b0;
         s1_level <= '0;
      end else begin
         s1_valid <= bus.pix_valid_in;
         s1_hit   <= hit_c;
         s1_bg    <= bg_color(shown_screen, bus.DrawX[9:3], bus.DrawY[9:3]);
         s1_show  <= SHOW_MASK[shown_screen];
         s1_level <= level;
      end
   end

   always_comb begin
      sel_c = s1_bg;
      if (s1_show) begin
         for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (s1_hit[i]) sel_c = bus.obj_rgb[i*24 +: 24];
         end
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q.r     <= scale(sel_c.r, s1_level);
         out_q.g     <= scale(sel_c.g, s1_level);
         out_q.b     <= scale(sel_c.b, s1_level);
         out_valid_q <= s1_valid;
      end
   end

   assign bus.Red           = out_q.r;
   assign bus.Green         = out_q.g;
   assign bus.Blue          = out_q.b;
   assign bus.pix_valid_out = out_valid_q;
   assign bus.fade_busy     = fade_busy_q;
endmodule
